intersection_phase_scheduler: RTL and testbench
===============================================

# intersection_phase_scheduler

Round-robin phase scheduler for an N-approach signalised intersection. It arbitrates green time among approach vehicle sensors and enforces minimum green, maximum green, yellow and all-red clearance intervals. It drives one 3-bit light per approach and sits above the per-road light outputs as the single owner of right-of-way. Only one approach is ever non-red.

## Interface
Parameters:
- `N_APPROACH`, 4: number of approaches, 2..8.
- `MIN_GREEN`, 20: minimum green, clk cycles, ≥1.
- `MAX_GREEN`, 60: maximum green when contested, clk cycles, ≥ MIN_GREEN.
- `YELLOW_T`, 5: yellow interval, clk cycles, ≥1.
- `ALL_RED_T`, 2: all-red clearance, clk cycles, ≥1.
- `TMR_W`, 24: phase timer width; must hold the largest of the above.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `sensor` in N_APPROACH: per-approach vehicle-waiting level.
- `preempt` in 1: emergency preemption request (level).
- `preempt_dir` in clog2(N_APPROACH): approach to preempt to.
- `light` out 3*N_APPROACH: approach i occupies bits [3i+2:3i]. Encodings are RED=100, YELLOW=010, GREEN=001.
- `grant` out clog2(N_APPROACH): index of the approach owning right-of-way.
- `phase` out 2: 00 GREEN, 01 YELLOW, 10 ALL_RED.
- `preempt_ack` out 1: high while a preemption is being served.

## Operation
- `sensor` is registered once (`sensor_q`). All decisions use `sensor_q`.
- `others` is the OR of `sensor_q` over all approaches except `grant`.
- The FSM has three states: GREEN, YELLOW and ALL_RED.
- GREEN leaves to YELLOW when the elapsed green is ≥ MIN_GREEN, `others`=1, and either:
  - `sensor_q[grant]`=0 (gap-out), or
  - elapsed green = MAX_GREEN (max-out).
- GREEN with `others`=0 holds indefinitely (rest in green), regardless of MAX_GREEN.
- YELLOW lasts exactly YELLOW_T cycles, then goes to ALL_RED.
- ALL_RED lasts exactly ALL_RED_T cycles. It then enters GREEN with a new `grant`:
  - The new grant is the first approach with `sensor_q` set, searching (grant+1) … (grant+N-1) modulo N.
  - If none is set, `grant` is unchanged and the same approach gets green again.
- `grant` changes only on the ALL_RED→GREEN transition.
- Lights:
  - The granted approach shows GREEN in GREEN and YELLOW in YELLOW.
  - All approaches show RED in ALL_RED.
  - Non-granted approaches are always RED.
- The phase timer clears on every state entry and increments each cycle. It saturates at all-ones and never wraps.

## Timing
- Reset values:
  - State GREEN, `grant`=0, timer=0.
  - `light`: approach 0 = GREEN, all others = RED.
  - `phase`=00, `preempt_ack`=0, `sensor_q`=0.
- All outputs are registered and change on the same edge as the state change.
- Sensor-to-decision latency is 1 cycle.
- Minimum cycle for one approach handoff: MIN_GREEN + YELLOW_T + ALL_RED_T cycles.
- Requests that drop during YELLOW or ALL_RED are ignored for the current transition. Only the `sensor_q` value in the last ALL_RED cycle selects the next grant.
- Reset asserted mid-phase returns to the reset state on the next edge. No yellow or all-red is inserted.
- If all sensors are active, service is strict rotation 0→1→…→N-1→0.

## Configuration
- `TLC_EMERGENCY_PREEMPT_EN` defined, with `preempt`=1:
  - In GREEN with `grant`≠`preempt_dir`: go to YELLOW next cycle, ignoring MIN_GREEN.
  - In GREEN with `grant`=`preempt_dir`: hold GREEN, ignoring gap-out and max-out.
  - At the end of ALL_RED, the next grant is forced to `preempt_dir`.
  - `preempt_ack`=1 from acceptance until `preempt` falls. Normal rotation then resumes from `preempt_dir`.
  - `preempt` is not registered; it is sampled directly.
- Macro undefined: `preempt` and `preempt_dir` are ignored, `preempt_ack` is tied to 0, and no preemption logic is synthesised.

## Structure
- Shared package `traffic_pkg`:
  - Light encodings RED/YELLOW/GREEN.
  - Phase enum GREEN/YELLOW/ALL_RED (2-bit).
  - Default timing constants.
- Sub-module `rr_pick`: combinational, taking `req[N]` and `cur` and returning `next` and `found`. It implements the rotating first-set search.
- The top level holds the FSM, the timer, `sensor_q` and the output registers.

## Test plan
Default parameters apply; cycle 0 is the first edge after `rst` falls.
- Reset, no sensors → approach 0 GREEN, others RED, held 200 cycles. `phase`=00 and `grant`=0 throughout.
- `sensor[2]`=1 held from cycle 0 → approach 0 GREEN for 20 cycles, YELLOW 5, ALL_RED 2. Approach 2 goes GREEN at cycle 27 with `grant`=2.
- `sensor[0]` and `sensor[1]` both held → approach 0 max-outs at 60 cycles. Approach 1 gets green after 7 clearance cycles. Approach 0 returns after approach 1's 60-cycle max.
- `sensor[3]` pulsed for 3 cycles during approach 0's green only → YELLOW at MIN_GREEN. ALL_RED ends with no request, so approach 0 is re-granted (`grant`=0).
- `rst` asserted during YELLOW → next cycle approach 0 GREEN, `phase`=00, timer=0.
- With the macro defined, `preempt`=1 and `preempt_dir`=3 at cycle 5 → YELLOW at cycle 6. Approach 3 is GREEN after the clearance, `preempt_ack`=1, and it holds past 60 cycles while `preempt` stays high.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection phase scheduler: light encodings,
// the phase enumeration and default timing constants.
package traffic_pkg;

  // Per-approach light encodings (one-hot, RED in the MSB).
  localparam logic [2:0] LT_RED    = 3'b100;
  localparam logic [2:0] LT_YELLOW = 3'b010;
  localparam logic [2:0] LT_GREEN  = 3'b001;

  // Controller phase; the encoding is driven straight onto the phase output.
  typedef enum logic [1:0] {
    PH_GREEN   = 2'b00,
    PH_YELLOW  = 2'b01,
    PH_ALL_RED = 2'b10
  } phase_e;

  // Default timing, in clk cycles.
  localparam int DEF_N_APPROACH = 4;
  localparam int DEF_MIN_GREEN  = 20;
  localparam int DEF_MAX_GREEN  = 60;
  localparam int DEF_YELLOW_T   = 5;
  localparam int DEF_ALL_RED_T  = 2;
  localparam int DEF_TMR_W      = 24;

endpackage

// File: rtl/rr_pick.sv
// Rotating first-set search: returns the first asserted request after cur,
// scanning cur+1 .. cur+N-1 modulo N. cur itself is never selected; when no
// other request is set, next echoes cur and found is low.
module rr_pick #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] cur,
  output logic [W-1:0] next,
  output logic         found
);

  // Scan from the farthest offset down so the nearest set request wins.
  always_comb begin
    logic [W-1:0] w_idx;
    next  = cur;
    found = 1'b0;
    w_idx = '0;
    for (int k = N - 1; k >= 1; k--) begin
      w_idx = W'((int'(cur) + k) % N);
      if (req[w_idx]) begin
        next  = w_idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Round-robin phase scheduler for an N-approach signalised intersection.
// Owns right-of-way: exactly one approach may be non-red at any time.
// Optional emergency preemption is compiled in with TLC_EMERGENCY_PREEMPT_EN;
// without it preempt/preempt_dir are ignored and preempt_ack stays low.
module intersection_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int N_APPROACH = DEF_N_APPROACH,
  parameter int MIN_GREEN  = DEF_MIN_GREEN,
  parameter int MAX_GREEN  = DEF_MAX_GREEN,
  parameter int YELLOW_T   = DEF_YELLOW_T,
  parameter int ALL_RED_T  = DEF_ALL_RED_T,
  parameter int TMR_W      = DEF_TMR_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_APPROACH-1:0]         sensor,
  input  logic                          preempt,
  input  logic [$clog2(N_APPROACH)-1:0] preempt_dir,
  output logic [3*N_APPROACH-1:0]       light,
  output logic [$clog2(N_APPROACH)-1:0] grant,
  output logic [1:0]                    phase,
  output logic                          preempt_ack
);

  localparam int GW = $clog2(N_APPROACH);

  // Timer compare points. Yellow and all-red leave on their last cycle so
  // they last exactly YELLOW_T / ALL_RED_T cycles.
  localparam logic [TMR_W-1:0] C_MIN      = TMR_W'(MIN_GREEN);
  localparam logic [TMR_W-1:0] C_MAX      = TMR_W'(MAX_GREEN);
  localparam logic [TMR_W-1:0] C_YEL_LAST = TMR_W'(YELLOW_T - 1);
  localparam logic [TMR_W-1:0] C_AR_LAST  = TMR_W'(ALL_RED_T - 1);

  phase_e                  r_state;
  logic [GW-1:0]           r_grant;
  logic [TMR_W-1:0]        r_tmr;
  logic [N_APPROACH-1:0]   r_sensor_q;
  logic [3*N_APPROACH-1:0] r_light;
  logic                    r_ack;

  phase_e                  w_state_next;
  logic [GW-1:0]           w_grant_next;
  logic [3*N_APPROACH-1:0] w_light_next;
  logic [3*N_APPROACH-1:0] w_rst_light;
  logic [N_APPROACH-1:0]   w_grant_mask;
  logic                    w_others;
  logic                    w_own;
  logic [GW-1:0]           w_rr_next;
  logic                    w_rr_found;
  logic                    w_pre_cut;
  logic                    w_pre_hold;
  logic                    w_pre_force;
  logic [GW-1:0]           w_pre_dir;
  logic                    w_ack_next;

  // One-hot of the current grant, the reset light pattern, and the next
  // light pattern derived from the next state so lights move with the phase.
  for (genvar gi = 0; gi < N_APPROACH; gi++) begin : g_appr
    assign w_grant_mask[gi] = (r_grant == GW'(gi));
    assign w_rst_light[3*gi +: 3] = (gi == 0) ? LT_GREEN : LT_RED;
    assign w_light_next[3*gi +: 3] =
      (w_grant_next != GW'(gi))   ? LT_RED    :
      (w_state_next == PH_GREEN)  ? LT_GREEN  :
      (w_state_next == PH_YELLOW) ? LT_YELLOW : LT_RED;
  end

  assign w_others = |(r_sensor_q & ~w_grant_mask);
  assign w_own    = |(r_sensor_q & w_grant_mask);

  rr_pick #(
    .N (N_APPROACH),
    .W (GW)
  ) u_rr_pick (
    .req   (r_sensor_q),
    .cur   (r_grant),
    .next  (w_rr_next),
    .found (w_rr_found)
  );

`ifdef TLC_EMERGENCY_PREEMPT_EN
  // preempt is a level sampled directly; the ack simply follows it by a cycle.
  assign w_pre_cut   = preempt && (r_grant != preempt_dir);
  assign w_pre_hold  = preempt && (r_grant == preempt_dir);
  assign w_pre_force = preempt;
  assign w_pre_dir   = preempt_dir;
  assign w_ack_next  = preempt;
`else
  logic w_unused_pre;
  assign w_unused_pre = ^{preempt, preempt_dir};
  assign w_pre_cut    = 1'b0;
  assign w_pre_hold   = 1'b0;
  assign w_pre_force  = 1'b0;
  assign w_pre_dir    = '0;
  assign w_ack_next   = 1'b0;
`endif

  // Next-state and next-grant decisions; grant only moves on ALL_RED->GREEN.
  always_comb begin
    w_state_next = r_state;
    w_grant_next = r_grant;
    case (r_state)
      PH_GREEN: begin
        if (w_pre_cut) begin
          w_state_next = PH_YELLOW;
        end else if (!w_pre_hold && w_others && (r_tmr >= C_MIN) &&
                     (!w_own || (r_tmr >= C_MAX))) begin
          w_state_next = PH_YELLOW;
        end
      end
      PH_YELLOW: begin
        if (r_tmr == C_YEL_LAST) begin
          w_state_next = PH_ALL_RED;
        end
      end
      PH_ALL_RED: begin
        if (r_tmr == C_AR_LAST) begin
          w_state_next = PH_GREEN;
          if (w_pre_force) begin
            w_grant_next = w_pre_dir;
          end else if (w_rr_found) begin
            w_grant_next = w_rr_next;
          end
        end
      end
      default: begin
        w_state_next = PH_GREEN;
      end
    endcase
  end

  // Phase FSM, saturating phase timer, sensor register and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= PH_GREEN;
      r_grant    <= '0;
      r_tmr      <= '0;
      r_sensor_q <= '0;
      r_light    <= w_rst_light;
      r_ack      <= 1'b0;
    end else begin
      r_sensor_q <= sensor;
      r_state    <= w_state_next;
      r_grant    <= w_grant_next;
      r_light    <= w_light_next;
      r_ack      <= w_ack_next;
      if (w_state_next != r_state) begin
        r_tmr <= '0;
      end else if (r_tmr != {TMR_W{1'b1}}) begin
        r_tmr <= r_tmr + 1'b1;
      end
    end
  end

  assign light       = r_light;
  assign grant       = r_grant;
  assign phase       = r_state;
  assign preempt_ack = r_ack;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Scenario bench for intersection_phase_scheduler (default parameters).
// Each scenario queues timed stimulus records and expected-output records;
// the runner resets the DUT, then walks cycles, driving stimulus before edge
// c and comparing expectations stamped c one time unit after edge c.
// Cycle 0 is the first edge with rst low.
module tb_intersection_phase_scheduler;

  localparam logic [1:0] G  = 2'b00;
  localparam logic [1:0] Y  = 2'b01;
  localparam logic [1:0] AR = 2'b10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  sensor = 4'b0000;
  logic        preempt = 1'b0;
  logic [1:0]  preempt_dir = 2'b00;
  logic [11:0] light;
  logic [1:0]  grant;
  logic [1:0]  phase;
  logic        preempt_ack;

  always #5 clk = ~clk;

  intersection_phase_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .sensor      (sensor),
    .preempt     (preempt),
    .preempt_dir (preempt_dir),
    .light       (light),
    .grant       (grant),
    .phase       (phase),
    .preempt_ack (preempt_ack)
  );

  typedef struct {
    int         cyc;
    logic       r;
    logic [3:0] sen;
    logic       pre;
    logic [1:0] dir;
  } stim_t;

  typedef struct {
    int         cyc;
    logic [1:0] ph;
    logic [1:0] gr;
    logic       ack;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  // Light vector implied by a phase and grant: only the granted approach
  // may be non-red, and never in ALL_RED.
  function automatic logic [11:0] exp_light(input logic [1:0] ph, input logic [1:0] gr);
    logic [11:0] v;
    int g;
    g = int'(gr);
    for (int i = 0; i < 4; i++) v[3*i +: 3] = 3'b100;
    if (ph == G) v[3*g +: 3] = 3'b001;
    else if (ph == Y) v[3*g +: 3] = 3'b010;
    return v;
  endfunction

  task automatic st(input int c, input logic r, input logic [3:0] s,
                    input logic p, input logic [1:0] d);
    stim_t e;
    e.cyc = c; e.r = r; e.sen = s; e.pre = p; e.dir = d;
    stim_q.push_back(e);
  endtask

  task automatic ex(input int c, input logic [1:0] ph, input logic [1:0] gr, input logic ack);
    exp_t e;
    e.cyc = c; e.ph = ph; e.gr = gr; e.ack = ack;
    exp_q.push_back(e);
  endtask

  task automatic compare(input string nm, input exp_t e);
    logic [11:0] el;
    el = exp_light(e.ph, e.gr);
    n_checks++;
    if (phase !== e.ph || grant !== e.gr || light !== el || preempt_ack !== e.ack) begin
      n_errors++;
      $display("FAIL %s cyc=%0d: got phase=%b grant=%0d light=%h ack=%b, want phase=%b grant=%0d light=%h ack=%b",
               nm, e.cyc, phase, grant, light, preempt_ack, e.ph, e.gr, el, e.ack);
    end else begin
      $display("ok   %s cyc=%0d: phase=%b grant=%0d light=%h ack=%b",
               nm, e.cyc, phase, grant, light, preempt_ack);
    end
  endtask

  task automatic run_scn(input string nm, input int ncyc);
    exp_t rst_e;
    rst = 1'b1; sensor = 4'b0000; preempt = 1'b0; preempt_dir = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    rst_e.cyc = -1; rst_e.ph = G; rst_e.gr = 2'd0; rst_e.ack = 1'b0;
    compare({nm, "/reset"}, rst_e);
    rst = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      while (stim_q.size() > 0 && stim_q[0].cyc == c) begin
        rst         = stim_q[0].r;
        sensor      = stim_q[0].sen;
        preempt     = stim_q[0].pre;
        preempt_dir = stim_q[0].dir;
        void'(stim_q.pop_front());
      end
      @(posedge clk);
      #1;
      while (exp_q.size() > 0 && exp_q[0].cyc == c) begin
        compare(nm, exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: %0d expectations never reached, want 0", nm, exp_q.size());
      exp_q.delete();
    end
    stim_q.delete();
  endtask

  initial begin
    // No demand: approach 0 rests in green.
    ex(0, G, 0, 0); ex(50, G, 0, 0); ex(100, G, 0, 0); ex(199, G, 0, 0);
    run_scn("idle", 200);

    // Single request on approach 2: min green, yellow, all-red, handoff.
    st(0, 0, 4'b0100, 0, 0);
    ex(19, G, 0, 0); ex(20, Y, 0, 0); ex(24, Y, 0, 0); ex(25, AR, 0, 0);
    ex(26, AR, 0, 0); ex(27, G, 2, 0); ex(120, G, 2, 0);
    run_scn("gapout", 130);

    // Approaches 0 and 1 both held: max-out on each.
    st(0, 0, 4'b0011, 0, 0);
    ex(59, G, 0, 0); ex(60, Y, 0, 0); ex(66, AR, 0, 0); ex(67, G, 1, 0);
    ex(127, G, 1, 0); ex(128, Y, 1, 0); ex(134, AR, 1, 0); ex(135, G, 0, 0);
    run_scn("maxout", 140);

    // Approach 3 pulses across min green then drops: re-grant approach 0.
    st(18, 0, 4'b1000, 0, 0); st(21, 0, 4'b0000, 0, 0);
    ex(17, G, 0, 0); ex(20, Y, 0, 0); ex(26, AR, 0, 0); ex(27, G, 0, 0); ex(80, G, 0, 0);
    run_scn("pulse", 90);

    // Reset during yellow: straight back to green, timer restarted.
    st(0, 0, 4'b0100, 0, 0); st(22, 1, 4'b0100, 0, 0); st(23, 0, 4'b0100, 0, 0);
    ex(21, Y, 0, 0); ex(22, G, 0, 0); ex(42, G, 0, 0); ex(43, Y, 0, 0);
    run_scn("rst_mid", 50);

    // All approaches demanding: strict rotation.
    st(0, 0, 4'b1111, 0, 0);
    ex(67, G, 1, 0); ex(135, G, 2, 0); ex(203, G, 3, 0); ex(271, G, 0, 0);
    run_scn("rotate", 275);

    // Preemption to approach 3 while approach 0 also demands.
    st(0, 0, 4'b0001, 0, 0); st(6, 0, 4'b0001, 1, 3); st(100, 0, 4'b0001, 0, 3);
`ifdef TLC_EMERGENCY_PREEMPT_EN
    ex(5, G, 0, 0); ex(6, Y, 0, 1); ex(11, AR, 0, 1); ex(13, G, 3, 1);
    ex(93, G, 3, 1); ex(99, G, 3, 1); ex(100, Y, 3, 0); ex(107, G, 0, 0);
`else
    ex(5, G, 0, 0); ex(6, G, 0, 0); ex(50, G, 0, 0); ex(100, G, 0, 0);
`endif
    run_scn("preempt", 110);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
